// File: rtl/synth_pkg.sv
// Shared width defaults for the audio synthesis chain.
package synth_pkg;
  localparam int SYNTH_SAMPLE_W = 8;
  localparam int SYNTH_FCW_W    = 8;
endpackage

// File: rtl/phase_accumulator.sv
// Modular phase accumulator: adds the increment every clock, carry out is dropped.
module phase_accumulator
  import synth_pkg::*;
#(
  parameter int ACC_WIDTH = SYNTH_SAMPLE_W,
  parameter int FCW_WIDTH = SYNTH_FCW_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [FCW_WIDTH-1:0] fcw_i,
  output logic [ACC_WIDTH-1:0] phase_o
);

  logic [ACC_WIDTH-1:0] phase_q;
  logic [ACC_WIDTH-1:0] phase_d;

  // Truncation to ACC_WIDTH bits is the sawtooth wrap.
  always_comb begin
    phase_d = phase_q + ACC_WIDTH'(fcw_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/sawtooth_wave_gen.sv
// Sawtooth oscillator: the output is the top OUT_WIDTH bits of a phase accumulator.
module sawtooth_wave_gen
  import synth_pkg::*;
#(
  parameter int ACC_WIDTH = SYNTH_SAMPLE_W,
  parameter int FCW_WIDTH = SYNTH_FCW_W,
  parameter int OUT_WIDTH = SYNTH_SAMPLE_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [FCW_WIDTH-1:0] frequency_control,
  output logic [OUT_WIDTH-1:0] sawtooth_out
);

  if (ACC_WIDTH < FCW_WIDTH) begin : g_bad_fcw_width
    $error("sawtooth_wave_gen: ACC_WIDTH must be >= FCW_WIDTH");
  end
  if (ACC_WIDTH < OUT_WIDTH) begin : g_bad_out_width
    $error("sawtooth_wave_gen: ACC_WIDTH must be >= OUT_WIDTH");
  end

  logic [ACC_WIDTH-1:0] phase;

  phase_accumulator #(
    .ACC_WIDTH (ACC_WIDTH),
    .FCW_WIDTH (FCW_WIDTH)
  ) u_phase_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .fcw_i   (frequency_control),
    .phase_o (phase)
  );

  // No output register: the sample appears on the same edge the phase updates.
  assign sawtooth_out = phase[ACC_WIDTH-1 -: OUT_WIDTH];

endmodule

// File: tb/tb_sawtooth_wave_gen.sv
// Directed self-checking bench for sawtooth_wave_gen (8-bit and 16-bit accumulators).
module tb_sawtooth_wave_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] fcw;
  logic [7:0] out;
  logic       reset_n_w;
  logic [7:0] fcw_w;
  logic [7:0] out_w;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sawtooth_wave_gen dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .frequency_control (fcw),
    .sawtooth_out      (out)
  );

  sawtooth_wave_gen #(
    .ACC_WIDTH (16),
    .FCW_WIDTH (8),
    .OUT_WIDTH (8)
  ) dut_wide (
    .clk               (clk),
    .reset_n           (reset_n_w),
    .frequency_control (fcw_w),
    .sawtooth_out      (out_w)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag, input logic [7:0] exp);
    tick();
    check(tag, out, exp);
  endtask

  // Reset between edges, confirm immediate clear, release with a new increment.
  task automatic restart(input logic [7:0] new_fcw);
    reset_n = 1'b0;
    #1;
    check("rst_async", out, 8'd0);
    fcw = new_fcw;
    tick();
    reset_n = 1'b1;
  endtask

  logic [7:0] ramp32 [11] = '{8'd32, 8'd64, 8'd96, 8'd128, 8'd160, 8'd192,
                              8'd224, 8'd0, 8'd32, 8'd64, 8'd96};

  initial begin
    reset_n   = 1'b0;
    fcw       = 8'd32;
    reset_n_w = 1'b0;
    fcw_w     = 8'd32;
    #1;
    check("rst_init", out, 8'd0);
    check("rst_init_w", out_w, 8'd0);

    for (int i = 0; i < 3; i++) step_check("rst_hold", 8'd0);

    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) step_check("ramp32", ramp32[i]);

    fcw = 8'd0;
    for (int i = 0; i < 20; i++) step_check("hold96", 8'd96);

    restart(8'd32);
    step_check("step_a", 8'd32);
    step_check("step_b", 8'd64);
    step_check("step_c", 8'd96);
    fcw = 8'd64;
    step_check("step64_a", 8'd160);
    step_check("step64_b", 8'd224);
    step_check("step64_wrap", 8'd32);

    restart(8'd255);
    step_check("desc_a", 8'd255);
    step_check("desc_b", 8'd254);
    step_check("desc_c", 8'd253);

    restart(8'd200);
    step_check("fcw200_a", 8'd200);
    step_check("fcw200_b", 8'd144);
    step_check("fcw200_c", 8'd88);
    step_check("fcw200_d", 8'd32);

    restart(8'd32);
    for (int i = 0; i < 5; i++) step_check("pre_rst", ramp32[i]);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_clear", out, 8'd0);
    step_check("mid_rst_hold", 8'd0);
    reset_n = 1'b1;
    step_check("post_rst", 8'd32);
    step_check("post_rst_b", 8'd64);

    check("wide_in_rst", out_w, 8'd0);
    reset_n_w = 1'b1;
    for (int c = 1; c <= 2048; c++) begin
      tick();
      if (c == 7)    check("wide_c7", out_w, 8'd0);
      if (c == 8)    check("wide_c8", out_w, 8'd1);
      if (c == 16)   check("wide_c16", out_w, 8'd2);
      if (c == 1024) check("wide_c1024", out_w, 8'd128);
      if (c == 2047) check("wide_c2047", out_w, 8'd255);
      if (c == 2048) check("wide_wrap", out_w, 8'd0);
    end
    tick();
    check("wide_c2049", out_w, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
